// File: rtl/frame_pair_feeder_if.sv
// Chunk-input and averager-pair handshake bundle for frame_pair_feeder.
// master = upstream/averager side, slave = the feeder itself.
interface frame_pair_feeder_if #(
    parameter int unsigned CHUNK_W          = 384,
    parameter int unsigned CHUNKS_PER_FRAME = 3600
);
    localparam int unsigned ADDR_W = $clog2(CHUNKS_PER_FRAME);

    logic               in_valid;
    logic               in_ready;
    logic [CHUNK_W-1:0] in_chunk;
    logic               in_sof;
    logic               pair_valid;
    logic               pair_ready;
    logic [CHUNK_W-1:0] pair_last;
    logic [CHUNK_W-1:0] pair_current;
    logic [ADDR_W-1:0]  pair_index;
    logic               pair_eof;
    logic               err_resync;

    modport master (
        output in_valid, in_chunk, in_sof, pair_ready,
        input  in_ready, pair_valid, pair_last, pair_current, pair_index,
               pair_eof, err_resync
    );

    modport slave (
        input  in_valid, in_chunk, in_sof, pair_ready,
        output in_ready, pair_valid, pair_last, pair_current, pair_index,
               pair_eof, err_resync
    );
endinterface

// File: rtl/frame_pair_feeder.sv
// Stores each incoming chunk in a previous-frame RAM and presents it paired
// with the co-located chunk of the previous frame for the frame averager.
module frame_pair_feeder #(
    parameter int unsigned CHUNK_W          = 384,
    parameter int unsigned CHUNKS_PER_FRAME = 3600
) (
    input logic                 clk,
    input logic                 rst,
    frame_pair_feeder_if.slave  bus
);
    localparam int unsigned ADDR_W = $clog2(CHUNKS_PER_FRAME);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CHUNKS_PER_FRAME - 1);

    typedef enum logic [1:0] {
        ACCEPT,
        FETCH,
        PRESENT
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  idx;
    logic               have_prev;
    logic               synced;
    logic [CHUNK_W-1:0] cur_q;
    logic [CHUNK_W-1:0] rdata;
    logic [CHUNK_W-1:0] mem [CHUNKS_PER_FRAME];

    logic               in_ready_q;
    logic               pair_valid_q;
    logic [CHUNK_W-1:0] pair_last_q;
    logic [CHUNK_W-1:0] pair_current_q;
    logic               pair_eof_q;
    logic               err_q;

    logic               take;
    logic               pair_hs;
    logic [ADDR_W-1:0]  rd_addr;

    // Non-sof chunks are only taken once a frame start has been seen.
    assign take    = (state == ACCEPT) && bus.in_valid && (synced || bus.in_sof);
    assign pair_hs = (state == PRESENT) && bus.pair_ready;
    assign rd_addr = bus.in_sof ? '0 : idx;

    // Previous-frame store: no reset, read on accept, written on pair transfer.
    always_ff @(posedge clk) begin
        if (take)
            rdata <= mem[rd_addr];
        if (pair_hs)
            mem[idx] <= cur_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ACCEPT;
            idx            <= '0;
            have_prev      <= 1'b0;
            synced         <= 1'b0;
            cur_q          <= '0;
            in_ready_q     <= 1'b1;
            pair_valid_q   <= 1'b0;
            pair_last_q    <= '0;
            pair_current_q <= '0;
            pair_eof_q     <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ACCEPT: begin
                    if (take) begin
                        cur_q <= bus.in_chunk;
                        if (bus.in_sof) begin
                            idx    <= '0;
                            synced <= 1'b1;
                            if ((idx != '0) && synced) begin
                                err_q     <= 1'b1;
                                have_prev <= 1'b0;
                            end
                        end
                        in_ready_q <= 1'b0;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    pair_last_q    <= have_prev ? rdata : cur_q;
                    pair_current_q <= cur_q;
                    pair_valid_q   <= 1'b1;
                    pair_eof_q     <= (idx == LAST_IDX);
                    state          <= PRESENT;
                end
                PRESENT: begin
                    if (bus.pair_ready) begin
                        pair_valid_q <= 1'b0;
                        pair_eof_q   <= 1'b0;
                        if (idx == LAST_IDX) begin
                            idx       <= '0;
                            have_prev <= 1'b1;
                            synced    <= 1'b0;
                        end else begin
                            idx <= idx + ADDR_W'(1);
                        end
                        in_ready_q <= 1'b1;
                        state      <= ACCEPT;
                    end
                end
                default: begin
                    in_ready_q <= 1'b1;
                    state      <= ACCEPT;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.pair_valid   = pair_valid_q;
    assign bus.pair_last    = pair_last_q;
    assign bus.pair_current = pair_current_q;
    assign bus.pair_index   = idx;
    assign bus.pair_eof     = pair_eof_q;
    assign bus.err_resync   = err_q;
endmodule

// File: tb/tb_frame_pair_feeder.sv
// Directed bench for frame_pair_feeder with a 4-chunk frame and 16-bit chunks.
module tb_frame_pair_feeder;
    localparam int unsigned CW  = 16;
    localparam int unsigned CPF = 4;

    logic clk;
    logic rst;
    int unsigned total;
    int unsigned bad;

    frame_pair_feeder_if #(.CHUNK_W(CW), .CHUNKS_PER_FRAME(CPF)) bus ();

    frame_pair_feeder #(.CHUNK_W(CW), .CHUNKS_PER_FRAME(CPF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One accepted chunk: checks FETCH gap, pair contents 2 cycles after the
    // input handshake, an optional stall, and the return to ACCEPT.
    task automatic do_chunk(input logic [CW-1:0] data, input logic sof,
                            input logic [CW-1:0] exp_last, input int unsigned exp_idx,
                            input logic exp_err, input int unsigned stall);
        string p;
        p = $sformatf("c%0h", data);
        check_eq({p, "_rdy"}, 32'(bus.in_ready), 32'd1);
        bus.pair_ready = (stall == 0);
        bus.in_valid   = 1'b1;
        bus.in_chunk   = data;
        bus.in_sof     = sof;
        step();
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        check_eq({p, "_fetch_pv"}, 32'(bus.pair_valid), 32'd0);
        check_eq({p, "_fetch_rdy"}, 32'(bus.in_ready), 32'd0);
        check_eq({p, "_err"}, 32'(bus.err_resync), 32'(exp_err));
        step();
        check_eq({p, "_pv"}, 32'(bus.pair_valid), 32'd1);
        check_eq({p, "_last"}, 32'(bus.pair_last), 32'(exp_last));
        check_eq({p, "_cur"}, 32'(bus.pair_current), 32'(data));
        check_eq({p, "_idx"}, 32'(bus.pair_index), 32'(exp_idx));
        check_eq({p, "_eof"}, 32'(bus.pair_eof), 32'(exp_idx == CPF - 1));
        check_eq({p, "_err_gone"}, 32'(bus.err_resync), 32'd0);
        for (int unsigned s = 0; s < stall; s++) begin
            step();
            check_eq({p, "_hold_pv"}, 32'(bus.pair_valid), 32'd1);
            check_eq({p, "_hold_last"}, 32'(bus.pair_last), 32'(exp_last));
            check_eq({p, "_hold_cur"}, 32'(bus.pair_current), 32'(data));
            check_eq({p, "_hold_rdy"}, 32'(bus.in_ready), 32'd0);
        end
        bus.pair_ready = 1'b1;
        step();
        check_eq({p, "_done_pv"}, 32'(bus.pair_valid), 32'd0);
        check_eq({p, "_done_rdy"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic drop_chunk(input logic [CW-1:0] data);
        string p;
        p = $sformatf("drop%0h", data);
        check_eq({p, "_rdy"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_chunk = data;
        bus.in_sof   = 1'b0;
        step();
        bus.in_valid = 1'b0;
        check_eq({p, "_pv"}, 32'(bus.pair_valid), 32'd0);
        check_eq({p, "_rdy_after"}, 32'(bus.in_ready), 32'd1);
        step();
        check_eq({p, "_pv2"}, 32'(bus.pair_valid), 32'd0);
        check_eq({p, "_idx"}, 32'(bus.pair_index), 32'd0);
    endtask

    task automatic check_reset_state(input string p);
        check_eq({p, "_rdy"}, 32'(bus.in_ready), 32'd1);
        check_eq({p, "_pv"}, 32'(bus.pair_valid), 32'd0);
        check_eq({p, "_eof"}, 32'(bus.pair_eof), 32'd0);
        check_eq({p, "_err"}, 32'(bus.err_resync), 32'd0);
        check_eq({p, "_idx"}, 32'(bus.pair_index), 32'd0);
        check_eq({p, "_last"}, 32'(bus.pair_last), 32'd0);
        check_eq({p, "_cur"}, 32'(bus.pair_current), 32'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_chunk   = '0;
        bus.in_sof     = 1'b0;
        bus.pair_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("rst0");

        // Frame A: first frame, pairs equal the input
        for (int unsigned i = 0; i < CPF; i++)
            do_chunk(CW'(16'h10 + i), (i == 0), CW'(16'h10 + i), i, 1'b0, 0);

        // Frame B: previous frame is A
        for (int unsigned i = 0; i < CPF; i++)
            do_chunk(CW'(16'h20 + i), (i == 0), CW'(16'h10 + i), i, 1'b0, 0);

        // Frame C: stall the first pair for 5 cycles
        do_chunk(16'h40, 1'b1, 16'h20, 0, 1'b0, 5);
        for (int unsigned i = 1; i < CPF; i++)
            do_chunk(CW'(16'h40 + i), 1'b0, CW'(16'h20 + i), i, 1'b0, 0);

        // Reset, unsynced chunks dropped, then frame D as a first frame
        pulse_reset();
        check_reset_state("rst1");
        drop_chunk(16'h81);
        drop_chunk(16'h82);
        for (int unsigned i = 0; i < CPF; i++)
            do_chunk(CW'(16'h30 + i), (i == 0), CW'(16'h30 + i), i, 1'b0, 0);

        // Frame E: mid-frame sof at index 2 resyncs
        do_chunk(16'h60, 1'b1, 16'h30, 0, 1'b0, 0);
        do_chunk(16'h61, 1'b0, 16'h31, 1, 1'b0, 0);
        do_chunk(16'h50, 1'b1, 16'h50, 0, 1'b1, 0);
        do_chunk(16'h51, 1'b0, 16'h51, 1, 1'b0, 0);

        // Asynchronous reset while a pair is presented
        bus.pair_ready = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_chunk   = 16'h55;
        bus.in_sof     = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        step();
        check_eq("pre_rst_pv", 32'(bus.pair_valid), 32'd1);
        rst = 1'b1;
        #2;
        check_eq("async_rst_pv", 32'(bus.pair_valid), 32'd0);
        check_eq("async_rst_rdy", 32'(bus.in_ready), 32'd1);
        #1;
        rst            = 1'b0;
        bus.pair_ready = 1'b1;
        step();
        check_reset_state("rst2");
        for (int unsigned i = 0; i < CPF; i++)
            do_chunk(CW'(16'h70 + i), (i == 0), CW'(16'h70 + i), i, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
